// File: rtl/ps2_scan_buffer_if.sv
// PS/2 scan buffer bus: raw keyboard pins, FIFO pop/clear, status.
// master drives KB_Clk/KB_Data/Pop/Clear; slave returns byte/status.
interface ps2_scan_buffer_if #(
  parameter int DEPTH = 16
);
  logic                     KB_Clk;
  logic                     KB_Data;
  logic                     Pop;
  logic                     Clear;
  logic [7:0]               Kb_Byte;
  logic                     Valid;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Parity_Err;
  logic                     Frame_Err;
  logic                     Overflow;

  modport master (
    output KB_Clk, KB_Data, Pop, Clear,
    input  Kb_Byte, Valid, Count,
    input  Parity_Err, Frame_Err, Overflow
  );

  modport slave (
    input  KB_Clk, KB_Data, Pop, Clear,
    output Kb_Byte, Valid, Count,
    output Parity_Err, Frame_Err, Overflow
  );
endinterface

// File: rtl/ps2_scan_buffer.sv
// PS/2 frame receiver feeding a show-ahead scan-code FIFO.
// Ports: Fast_Clock, Reset (async high), bus (ps2_scan_buffer_if.slave).
// Optional macro BREAK_FILTER_EN drops 0xF0 and the byte after it.
module ps2_scan_buffer #(
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter int SYNC_STAGES    = 2
) (
  input logic              Fast_Clock,
  input logic              Reset,
  ps2_scan_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  logic [SYNC_STAGES-1:0] kclk_q, kclk_d;
  logic [SYNC_STAGES-1:0] kdat_q, kdat_d;
  logic                   kold_q, kold_d;
  logic                   fall, bit_in;

  state_t                 state_q, state_d;
  logic [2:0]             bcnt_q, bcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   good;
  logic                   push_req;

  logic [7:0]             mem_q [DEPTH];
  logic [AW-1:0]          wr_q, wr_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   valid, full;
  logic                   do_pop, do_push, we;

  // Falling edge: previous synced level 1, current synced level 0.
  always_comb begin
    kclk_d = {kclk_q[SYNC_STAGES-2:0], bus.KB_Clk};
    kdat_d = {kdat_q[SYNC_STAGES-2:0], bus.KB_Data};
    kold_d = kclk_q[SYNC_STAGES-1];
    fall   = kold_q & ~kclk_q[SYNC_STAGES-1];
    bit_in = kdat_q[SYNC_STAGES-1];
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    tmo_d   = '0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    good    = 1'b0;
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        ferr_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
    if (fall) begin
      unique case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d = DATA;
            bcnt_d  = 3'd0;
          end
        end
        DATA: begin
          shift_d[bcnt_q] = bit_in;
          if (bcnt_q == 3'd7) state_d = PARITY;
          else bcnt_d = bcnt_q + 3'd1;
        end
        PARITY: begin
          par_d   = bit_in;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!bit_in) ferr_d = 1'b1;
          else if (^{shift_q, par_q}) good = 1'b1;
          else perr_d = 1'b1;
        end
      endcase
    end
  end

`ifdef BREAK_FILTER_EN
  logic skip_q, skip_d;

  // 0xF0 arms a one-shot skip of the following good byte.
  always_comb begin
    skip_d   = skip_q;
    push_req = 1'b0;
    if (good) begin
      if (skip_q) skip_d = 1'b0;
      else if (shift_q == 8'hF0) skip_d = 1'b1;
      else push_req = 1'b1;
    end
    if (bus.Clear) skip_d = 1'b0;
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) skip_q <= 1'b0;
    else       skip_q <= skip_d;
  end
`else
  always_comb push_req = good;
`endif

  // Pop frees a slot, so a simultaneous push is accepted when full.
  always_comb begin
    valid   = cnt_q != '0;
    full    = cnt_q == CW'(DEPTH);
    do_pop  = bus.Pop & valid;
    do_push = push_req & (~full | do_pop);
    we      = do_push & ~bus.Clear;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.Clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop) cnt_d = cnt_q + CW'(1);
      if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
      if (push_req && !do_push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge Fast_Clock or posedge Reset) begin
    if (Reset) begin
      kclk_q  <= '1;
      kdat_q  <= '1;
      kold_q  <= 1'b1;
      state_q <= IDLE;
      bcnt_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      kclk_q  <= kclk_d;
      kdat_q  <= kdat_d;
      kold_q  <= kold_d;
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge Fast_Clock) begin
    if (we) mem_q[wr_q] <= shift_q;
  end

  always_comb begin
    bus.Kb_Byte    = valid ? mem_q[rd_q] : 8'h00;
    bus.Valid      = valid;
    bus.Count      = cnt_q;
    bus.Parity_Err = perr_q;
    bus.Frame_Err  = ferr_q;
    bus.Overflow   = ovf_q;
  end
endmodule
